// File: rtl/aexm_xecu_pkg.sv
// aexm_xecu_pkg: shared opcodes, multiplier FSM states and a width helper for the aexm execute unit
package aexm_xecu_pkg;

  localparam logic [2:0] MX_ADD = 3'd0;
  localparam logic [2:0] MX_LOG = 3'd1;
  localparam logic [2:0] MX_SFT = 3'd2;
  localparam logic [2:0] MX_MOV = 3'd3;
  localparam logic [2:0] MX_MUL = 3'd4;
  localparam logic [2:0] MX_BSF = 3'd5;

  localparam logic [1:0] LOG_OR   = 2'd0;
  localparam logic [1:0] LOG_AND  = 2'd1;
  localparam logic [1:0] LOG_XOR  = 2'd2;
  localparam logic [1:0] LOG_ANDN = 2'd3;

  localparam logic [1:0] SFT_SRA   = 2'd0;
  localparam logic [1:0] SFT_SRC   = 2'd1;
  localparam logic [1:0] SFT_SRL   = 2'd2;
  localparam logic [1:0] SFT_SEXT8 = 2'd3;

  localparam logic [1:0] BSF_SRL = 2'd0;
  localparam logic [1:0] BSF_SRA = 2'd1;
  localparam logic [1:0] BSF_SLL = 2'd2;
  localparam logic [1:0] BSF_RSV = 2'd3;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} mul_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/aexm_xecu_mul.sv
// aexm_xecu_mul: shift-and-add multiplier that stops as soon as the remaining multiplier bits are zero
module aexm_xecu_mul
  import aexm_xecu_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          gclk,
  input  logic          grst_n,
  input  logic          i_start,
  input  logic          i_flush,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  output logic          o_busy,
  output logic          o_done,
  output logic [DW-1:0] o_res
);

  localparam int CW = clog2(DW) + 1;

  mul_state_e    r_state, w_state_nx;
  logic [DW-1:0] r_a, r_b, r_acc, w_acc_nx, w_b_nx;
  logic [CW-1:0] r_cnt;
  logic          w_last;

  // one iteration step, completion test and next state; flush beats completion
  always_comb begin
    w_acc_nx   = r_b[0] ? r_acc + r_a : r_acc;
    w_b_nx     = r_b >> 1;
    w_last     = (w_b_nx == '0) || (r_cnt == CW'(1));
    w_state_nx = r_state;
    o_done     = 1'b0;
    if (r_state == S_IDLE) begin
      if (i_start && !i_flush) w_state_nx = S_RUN;
    end else if (i_flush) begin
      w_state_nx = S_IDLE;
    end else if (w_last) begin
      w_state_nx = S_IDLE;
      o_done     = 1'b1;
    end
  end

  assign o_busy = (r_state == S_RUN);
  assign o_res  = w_acc_nx;

  // state register plus operand capture on start and per-cycle iteration in RUN
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      if (r_state == S_IDLE && i_start && !i_flush) begin
        r_a   <= i_a;
        r_b   <= i_b;
        r_acc <= '0;
        r_cnt <= CW'(DW);
      end else if (r_state == S_RUN) begin
        r_a   <= r_a << 1;
        r_b   <= w_b_nx;
        r_acc <= w_acc_nx;
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/aexm_xecu_mc.sv
// aexm_xecu_mc: execute unit with single-cycle ALU paths, optional barrel shifter and iterative multiplier
module aexm_xecu_mc
  import aexm_xecu_pkg::*;
#(
  parameter int DW  = 32,
  parameter bit BSF = 1'b1,
  parameter bit MUL = 1'b1
) (
  input  logic          gclk,
  input  logic          grst_n,
  input  logic          x_en,
  input  logic          x_flush,
  input  logic          op_vld,
  input  logic [2:0]    op_mx,
  input  logic          op_sub,
  input  logic          op_ccc,
  input  logic          op_kc,
  input  logic [1:0]    op_log,
  input  logic [1:0]    op_sft,
  input  logic [1:0]    op_bsf,
  input  logic [DW-1:0] opa,
  input  logic [DW-1:0] opb,
  output logic          x_busy,
  output logic [DW-1:0] rRESULT,
  output logic          rRES_VLD,
  output logic          rMSR_C
);

  localparam int LW = clog2(DW);

  logic          w_acc, w_start, w_mul_done, w_cin, w_add_c, w_c_nx;
  logic [DW-1:0] w_add, w_log, w_sft, w_sra, w_bsf, w_res, w_mul_res;
  logic [LW-1:0] w_amt;

  assign w_amt = opb[LW-1:0];
  assign w_sra = $signed(opa) >>> w_amt;

  // single-cycle datapaths, result select and next carry
  always_comb begin
    w_cin            = op_ccc ? rMSR_C : op_sub;
    {w_add_c, w_add} = {1'b0, opb} + {1'b0, op_sub ? ~opa : opa} + {{DW{1'b0}}, w_cin};
    w_log = op_log == LOG_OR  ? opa | opb :
            op_log == LOG_AND ? opa & opb :
            op_log == LOG_XOR ? opa ^ opb : opa & ~opb;
    w_sft = op_sft == SFT_SEXT8 ? DW'(signed'(opa[7:0])) :
            {op_sft == SFT_SRA ? opa[DW-1] : op_sft == SFT_SRC ? rMSR_C : 1'b0, opa[DW-1:1]};
    w_bsf = !BSF                ? '0 :
            op_bsf == BSF_SRL   ? opa >> w_amt :
            op_bsf == BSF_SRA   ? w_sra :
            op_bsf == BSF_SLL   ? opa << w_amt : '0;
    w_res = op_mx == MX_ADD ? w_add :
            op_mx == MX_LOG ? w_log :
            op_mx == MX_SFT ? w_sft :
            op_mx == MX_MOV ? opb :
            op_mx == MX_BSF ? w_bsf : '0;
    w_c_nx = (op_mx == MX_ADD && !op_kc)                 ? w_add_c :
             (op_mx == MX_SFT && op_sft != SFT_SEXT8)    ? opa[0]  : rMSR_C;
    w_acc   = op_vld && x_en && !x_busy && !x_flush;
    w_start = w_acc && MUL && (op_mx == MX_MUL);
  end

  if (MUL) begin : g_mul
    aexm_xecu_mul #(.DW(DW)) u_mul (
      .gclk    (gclk),
      .grst_n  (grst_n),
      .i_start (w_start),
      .i_flush (x_flush),
      .i_a     (opa),
      .i_b     (opb),
      .o_busy  (x_busy),
      .o_done  (w_mul_done),
      .o_res   (w_mul_res)
    );
  end else begin : g_nomul
    assign x_busy     = 1'b0;
    assign w_mul_done = 1'b0;
    assign w_mul_res  = '0;
  end

  // commit single-cycle results on accept and multiply results on completion
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      rRESULT  <= '0;
      rRES_VLD <= 1'b0;
      rMSR_C   <= 1'b0;
    end else begin
      rRES_VLD <= (w_acc && !w_start) || w_mul_done;
      if (w_mul_done) begin
        rRESULT <= w_mul_res;
      end else if (w_acc && !w_start) begin
        rRESULT <= w_res;
        rMSR_C  <= w_c_nx;
      end
    end
  end

endmodule

// File: tb/tb_aexm_xecu_mc.sv
// tb_aexm_xecu_mc: scoreboard-driven checks of ALU paths, multiplier timing, flush and async reset
module tb_aexm_xecu_mc;

  logic        clk = 0, rst_n = 0, x_en = 1, x_flush = 0, op_vld = 0;
  logic        op_sub = 0, op_ccc = 0, op_kc = 0;
  logic [2:0]  op_mx = 0;
  logic [1:0]  op_log = 0, op_sft = 0, op_bsf = 0;
  logic [31:0] opa = 0, opb = 0;
  logic        x_busy, vld, c;
  logic [31:0] res;

  logic        v16 = 0, en16 = 1, fl16 = 0;
  logic [2:0]  mx16 = 0;
  logic [1:0]  bsf16 = 0;
  logic [15:0] a16 = 0, b16 = 0;
  logic        busy16, vld16, c16, busy16n, vld16n, c16n;
  logic [15:0] res16, res16n;

  typedef struct {logic [31:0] res; logic c; int busy;} exp_t;
  exp_t sb[$];
  int   total = 0, bad = 0;
  logic mc = 0;

  always #5 clk = ~clk;

  aexm_xecu_mc #(.DW(32), .BSF(1), .MUL(1)) dut (
    .gclk(clk), .grst_n(rst_n), .x_en(x_en), .x_flush(x_flush), .op_vld(op_vld),
    .op_mx(op_mx), .op_sub(op_sub), .op_ccc(op_ccc), .op_kc(op_kc), .op_log(op_log),
    .op_sft(op_sft), .op_bsf(op_bsf), .opa(opa), .opb(opb),
    .x_busy(x_busy), .rRESULT(res), .rRES_VLD(vld), .rMSR_C(c));

  aexm_xecu_mc #(.DW(16), .BSF(1), .MUL(1)) dut16 (
    .gclk(clk), .grst_n(rst_n), .x_en(en16), .x_flush(fl16), .op_vld(v16),
    .op_mx(mx16), .op_sub(op_sub), .op_ccc(op_ccc), .op_kc(op_kc), .op_log(op_log),
    .op_sft(op_sft), .op_bsf(bsf16), .opa(a16), .opb(b16),
    .x_busy(busy16), .rRESULT(res16), .rRES_VLD(vld16), .rMSR_C(c16));

  aexm_xecu_mc #(.DW(16), .BSF(0), .MUL(0)) dut16n (
    .gclk(clk), .grst_n(rst_n), .x_en(en16), .x_flush(fl16), .op_vld(v16),
    .op_mx(mx16), .op_sub(op_sub), .op_ccc(op_ccc), .op_kc(op_kc), .op_log(op_log),
    .op_sft(op_sft), .op_bsf(bsf16), .opa(a16), .opb(b16),
    .x_busy(busy16n), .rRESULT(res16n), .rRES_VLD(vld16n), .rMSR_C(c16n));

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic set_op(input logic [2:0] mx, input logic [31:0] a, b,
                        input logic sub, ccc, kc, input logic [1:0] lg, sf, bs);
    op_mx = mx; opa = a; opb = b; op_sub = sub; op_ccc = ccc; op_kc = kc;
    op_log = lg; op_sft = sf; op_bsf = bs;
  endtask

  task automatic fire();
    @(negedge clk);
    op_vld = 1;
    @(posedge clk);
    #1;
    op_vld = 0;
  endtask

  task automatic push_k(input logic [31:0] r, input logic cc);
    exp_t e;
    e.res = r; e.c = cc; e.busy = 0;
    mc = cc;
    sb.push_back(e);
  endtask

  task automatic push_model();
    exp_t e;
    logic [32:0] s;
    logic cin;
    logic [4:0] amt;
    e.busy = 0; e.c = mc; e.res = 0;
    amt = opb[4:0];
    case (op_mx)
      3'd0: begin
        cin = op_ccc ? mc : op_sub;
        s = {1'b0, opb} + {1'b0, (op_sub ? ~opa : opa)} + {32'b0, cin};
        e.res = s[31:0];
        if (!op_kc) e.c = s[32];
      end
      3'd1: e.res = op_log == 0 ? opa | opb : op_log == 1 ? opa & opb : op_log == 2 ? opa ^ opb : opa & ~opb;
      3'd2: if (op_sft == 3) e.res = {{24{opa[7]}}, opa[7:0]};
            else begin
              e.res = {op_sft == 0 ? opa[31] : op_sft == 1 ? mc : 1'b0, opa[31:1]};
              e.c = opa[0];
            end
      3'd3: e.res = opb;
      3'd4: begin
        e.res = opa * opb;
        e.busy = 1;
        for (int i = 0; i < 32; i++) if (opb[i]) e.busy = i + 1;
      end
      3'd5: case (op_bsf)
        2'd0: e.res = opa >> amt;
        2'd1: e.res = $signed(opa) >>> amt;
        2'd2: e.res = opa << amt;
        default: e.res = 0;
      endcase
      default: e.res = 0;
    endcase
    mc = e.c;
    sb.push_back(e);
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (x_busy && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic test_reset();
    #3;
    total++;
    if (res !== 0 || vld !== 0 || c !== 0 || x_busy !== 0) begin
      bad++;
      $display("FAIL reset: got res=%h vld=%b c=%b busy=%b want all zero", res, vld, c, x_busy);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_add_sub();
    exp_t e;
    logic [31:0] er;
    logic ec;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: begin set_op(0, 32'hFFFF_FFFF, 32'h1, 0, 0, 0, 0, 0, 0); er = 32'h0;         ec = 1; end
        1: begin set_op(0, 32'h5, 32'h3, 1, 0, 0, 0, 0, 0);         er = 32'hFFFF_FFFE; ec = 0; end
        2: begin set_op(2, 32'h3, 32'h0, 0, 0, 0, 0, 1, 0);         er = 32'h1;         ec = 1; end
        3: begin set_op(2, 32'h8000_0001, 32'h0, 0, 0, 0, 0, 0, 0); er = 32'hC000_0000; ec = 1; end
        4: begin set_op(2, 32'h8000_0002, 32'h0, 0, 0, 0, 0, 2, 0); er = 32'h4000_0001; ec = 0; end
        default: begin set_op(2, 32'h1234_5680, 32'h0, 0, 0, 0, 0, 3, 0); er = 32'hFFFF_FF80; ec = 0; end
      endcase
      push_k(er, ec);
      fire();
      e = sb.pop_front();
      total++;
      if (vld !== 1 || res !== e.res || c !== e.c) begin
        bad++;
        $display("FAIL add_sub[%0d]: got vld=%b res=%h c=%b want vld=1 res=%h c=%b", i, vld, res, c, e.res, e.c);
      end
    end
    @(posedge clk);
    #1;
    total++;
    if (vld !== 0) begin
      bad++;
      $display("FAIL vld_pulse: got vld=%b want 0", vld);
    end
  endtask

  task automatic test_alu();
    exp_t e;
    for (int i = 0; i < 26; i++) begin
      case (i)
        0:  set_op(1, 32'hF0F0_1234, 32'h0FF0_00FF, 0, 0, 0, 0, 0, 0);
        1:  set_op(1, 32'hF0F0_1234, 32'h0FF0_00FF, 0, 0, 0, 1, 0, 0);
        2:  set_op(1, 32'hF0F0_1234, 32'h0FF0_00FF, 0, 0, 0, 2, 0, 0);
        3:  set_op(1, 32'hF0F0_1234, 32'h0FF0_00FF, 0, 0, 0, 3, 0, 0);
        4:  set_op(3, 32'h1111_1111, 32'hCAFE_BABE, 0, 0, 0, 0, 0, 0);
        5:  set_op(6, 32'h1111_1111, 32'hCAFE_BABE, 0, 0, 0, 0, 0, 0);
        6:  set_op(7, 32'h1111_1111, 32'hCAFE_BABE, 0, 0, 0, 0, 0, 0);
        7:  set_op(2, 32'h1, 32'h0, 0, 0, 0, 0, 2, 0);
        8:  set_op(0, 32'h1, 32'h1, 0, 1, 0, 0, 0, 0);
        9:  set_op(2, 32'h1, 32'h0, 0, 0, 0, 0, 2, 0);
        10: set_op(0, 32'hFFFF_FFFF, 32'h1, 0, 0, 1, 0, 0, 0);
        11: set_op(0, 32'h7, 32'hA, 1, 1, 0, 0, 0, 0);
        12: set_op(2, 32'h10, 32'h0, 0, 0, 0, 0, 1, 0);
        13: set_op(5, 32'hF000_0000, 32'h4, 0, 0, 0, 0, 0, 0);
        14: set_op(5, 32'hF000_0000, 32'h24, 0, 0, 0, 0, 0, 1);
        15: set_op(5, 32'h1, 32'h1F, 0, 0, 0, 0, 0, 2);
        16: set_op(5, 32'hFFFF_FFFF, 32'h1, 0, 0, 0, 0, 0, 3);
        17: set_op(2, 32'h7F, 32'h0, 0, 0, 0, 0, 3, 0);
        default: set_op(0, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), 0, 0, 0);
      endcase
      push_model();
      fire();
      e = sb.pop_front();
      total++;
      if (vld !== 1 || res !== e.res || c !== e.c) begin
        bad++;
        $display("FAIL alu[%0d]: got vld=%b res=%h c=%b want vld=1 res=%h c=%b", i, vld, res, c, e.res, e.c);
      end
    end
  endtask

  task automatic test_mul();
    exp_t e;
    int n;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: set_op(4, 32'h7, 32'h5, 0, 0, 0, 0, 0, 0);
        1: set_op(4, 32'h9, 32'h0, 0, 0, 0, 0, 0, 0);
        2: set_op(4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0);
        3: set_op(4, 32'h1234, 32'h8000_0000, 0, 0, 0, 0, 0, 0);
        default: set_op(4, $urandom, $urandom >> $urandom_range(0, 31), 0, 0, 0, 0, 0, 0);
      endcase
      push_model();
      fire();
      wait_busy(n);
      e = sb.pop_front();
      total++;
      if (n !== e.busy || vld !== 1 || res !== e.res || c !== e.c) begin
        bad++;
        $display("FAIL mul[%0d]: got busy=%0d vld=%b res=%h c=%b want busy=%0d vld=1 res=%h c=%b",
                 i, n, vld, res, c, e.busy, e.res, e.c);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int n;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: set_op(4, 32'h6, 32'h3, 0, 0, 0, 0, 0, 0);
        1: set_op(4, 32'h10, 32'h100, 0, 0, 0, 0, 0, 0);
        default: set_op(0, 32'h20, 32'h22, 0, 0, 0, 0, 0, 0);
      endcase
      push_model();
      fire();
      wait_busy(n);
      e = sb.pop_front();
      total++;
      if (n !== e.busy || vld !== 1 || res !== e.res || c !== e.c) begin
        bad++;
        $display("FAIL b2b[%0d]: got busy=%0d vld=%b res=%h c=%b want busy=%0d vld=1 res=%h c=%b",
                 i, n, vld, res, c, e.busy, e.res, e.c);
      end
    end
  endtask

  task automatic test_flush();
    logic [31:0] prev;
    logic pc;
    prev = res;
    pc = c;
    set_op(4, 32'h3, 32'hFFFF, 0, 0, 0, 0, 0, 0);
    fire();
    @(negedge clk);
    set_op(0, 32'h1, 32'h1, 0, 0, 0, 0, 0, 0);
    op_vld = 1;
    @(posedge clk);
    #1;
    total++;
    if (vld !== 0 || x_busy !== 1) begin
      bad++;
      $display("FAIL busy_ignore: got vld=%b busy=%b want vld=0 busy=1", vld, x_busy);
    end
    @(negedge clk);
    x_flush = 1;
    @(posedge clk);
    #1;
    total++;
    if (x_busy !== 0 || vld !== 0 || res !== prev || c !== pc) begin
      bad++;
      $display("FAIL flush_run: got busy=%b vld=%b res=%h c=%b want busy=0 vld=0 res=%h c=%b", x_busy, vld, res, c, prev, pc);
    end
    @(negedge clk);
    total++;
    if (vld !== 0 || x_busy !== 0 || res !== prev) begin
      bad++;
      $display("FAIL flush_idle: got vld=%b busy=%b res=%h want vld=0 busy=0 res=%h", vld, x_busy, res, prev);
    end
    x_flush = 0;
    op_vld = 0;
    set_op(4, 32'h5, 32'h1, 0, 0, 0, 0, 0, 0);
    fire();
    @(negedge clk);
    x_flush = 1;
    @(posedge clk);
    #1;
    x_flush = 0;
    total++;
    if (x_busy !== 0 || vld !== 0 || res !== prev || c !== pc) begin
      bad++;
      $display("FAIL flush_done: got busy=%b vld=%b res=%h c=%b want busy=0 vld=0 res=%h c=%b", x_busy, vld, res, c, prev, pc);
    end
  endtask

  task automatic test_x_en();
    exp_t e;
    int n;
    x_en = 0;
    set_op(0, 32'h4, 32'h4, 0, 0, 0, 0, 0, 0);
    fire();
    total++;
    if (vld !== 0) begin
      bad++;
      $display("FAIL x_en_hold: got vld=%b want 0", vld);
    end
    x_en = 1;
    set_op(4, 32'hB, 32'hD, 0, 0, 0, 0, 0, 0);
    push_model();
    fire();
    x_en = 0;
    wait_busy(n);
    x_en = 1;
    e = sb.pop_front();
    total++;
    if (n !== e.busy || vld !== 1 || res !== e.res) begin
      bad++;
      $display("FAIL mul_no_en: got busy=%0d vld=%b res=%h want busy=%0d vld=1 res=%h", n, vld, res, e.busy, e.res);
    end
  endtask

  task automatic test_bsf16();
    logic [15:0] er;
    int n;
    mx16 = 5; a16 = 16'h8000; b16 = 16'h4;
    for (int i = 0; i < 4; i++) begin
      bsf16 = 2'(i);
      er = i == 0 ? 16'h0800 : i == 1 ? 16'hF800 : 16'h0000;
      @(negedge clk);
      v16 = 1;
      @(posedge clk);
      #1;
      v16 = 0;
      total++;
      if (vld16 !== 1 || res16 !== er) begin
        bad++;
        $display("FAIL bsf16[%0d]: got vld=%b res=%h want vld=1 res=%h", i, vld16, res16, er);
      end
      total++;
      if (vld16n !== 1 || res16n !== 16'h0) begin
        bad++;
        $display("FAIL bsf16_off[%0d]: got vld=%b res=%h want vld=1 res=0000", i, vld16n, res16n);
      end
    end
    mx16 = 4; a16 = 16'h3; b16 = 16'h2;
    @(negedge clk);
    v16 = 1;
    @(posedge clk);
    #1;
    v16 = 0;
    total++;
    if (vld16n !== 1 || res16n !== 16'h0 || busy16n !== 0 || busy16 !== 1) begin
      bad++;
      $display("FAIL mul_off16: got vld=%b res=%h busyn=%b busy=%b want vld=1 res=0000 busyn=0 busy=1",
               vld16n, res16n, busy16n, busy16);
    end
    n = 0;
    while (busy16 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (n !== 2 || vld16 !== 1 || res16 !== 16'h6) begin
      bad++;
      $display("FAIL mul16: got busy=%0d vld=%b res=%h want busy=2 vld=1 res=0006", n, vld16, res16);
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    set_op(0, 32'hFFFF_FFFF, 32'h2, 0, 0, 0, 0, 0, 0);
    push_model();
    fire();
    e = sb.pop_front();
    total++;
    if (vld !== 1 || res !== e.res || c !== e.c) begin
      bad++;
      $display("FAIL pre_reset_add: got vld=%b res=%h c=%b want vld=1 res=%h c=%b", vld, res, c, e.res, e.c);
    end
    set_op(4, 32'h3, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0);
    fire();
    @(posedge clk);
    #3;
    rst_n = 0;
    #1;
    total++;
    if (x_busy !== 0 || res !== 0 || vld !== 0 || c !== 0) begin
      bad++;
      $display("FAIL async_reset: got busy=%b res=%h vld=%b c=%b want all zero", x_busy, res, vld, c);
    end
    mc = 0;
    #2;
    rst_n = 1;
    set_op(0, 32'h2, 32'h3, 0, 0, 0, 0, 0, 0);
    push_model();
    fire();
    e = sb.pop_front();
    total++;
    if (vld !== 1 || res !== e.res || c !== e.c || x_busy !== 0) begin
      bad++;
      $display("FAIL post_reset_add: got vld=%b res=%h c=%b busy=%b want vld=1 res=%h c=%b busy=0",
               vld, res, c, x_busy, e.res, e.c);
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_alu();
    test_mul();
    test_back_to_back();
    test_flush();
    test_x_en();
    test_bsf16();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
